// File: rtl/msk_pkg.sv
// Shared definitions for the masked-register family: randomness width,
// share/mask bit indexing and refresh-mode encoding.
package msk_pkg;

   localparam int REFRESH_OFF = 0;
   localparam int REFRESH_ON  = 1;

   function automatic int rnd_width(input int d, input int count);
      return (d > 1) ? count * (d - 1) : 1;
   endfunction

   function automatic int share_idx(input int b, input int s, input int d);
      return b * d + s;
   endfunction

   function automatic int rnd_idx(input int b, input int k, input int d);
      return b * (d - 1) + k;
   endfunction

endpackage

// File: rtl/msk_refresh_xor.sv
// Combinational re-masking of a Boolean sharing: shares 0..d-2 take one fresh
// mask each, the last share absorbs the XOR of all of them.
module msk_refresh_xor
   import msk_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic [count*d-1:0]              in,
   input  logic [rnd_width(d, count)-1:0]  rnd,
   output logic [count*d-1:0]              out
);

   // Each output share sees only its own input share plus randomness.
   for (genvar gi = 0; gi < count; gi++) begin : g_bit
      logic [d-2:0] mask;
      assign mask = rnd[rnd_idx(gi, 0, d) +: (d - 1)];

      for (genvar gk = 0; gk < d - 1; gk++) begin : g_share
         assign out[share_idx(gi, gk, d)] = in[share_idx(gi, gk, d)] ^ mask[gk];
      end

      assign out[share_idx(gi, d - 1, d)] = in[share_idx(gi, d - 1, d)] ^ (^mask);
   end

endmodule

// File: rtl/msk_reg_pipe.sv
// Masked pipeline register: LAT stages of count*d shares with a travelling
// valid bit, common stall enable and optional refresh at stage 0.
module msk_reg_pipe
   import msk_pkg::*;
#(
   parameter int d       = 2,
   parameter int count   = 1,
   parameter int LAT     = 2,
   parameter int REFRESH = REFRESH_OFF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic                            in_valid,
   input  logic [count*d-1:0]              in,
   input  logic [rnd_width(d, count)-1:0]  rnd,
   output logic [count*d-1:0]              out,
   output logic                            out_valid
);

   localparam int W = count * d;

   logic [W-1:0]   s0_d;
   logic [W-1:0]   stage_q [LAT];
   logic [LAT-1:0] valid_q;

   if ((REFRESH == REFRESH_ON && d < 2) || LAT < 1 || d < 1 || count < 1) begin : g_illegal
      $error("msk_reg_pipe: illegal parameters (REFRESH=1 needs d>=2, LAT/d/count >= 1)");
   end else if (REFRESH == REFRESH_ON) begin : g_refresh
      msk_refresh_xor #(
         .d     (d),
         .count (count)
      ) u_refresh (
         .in  (in),
         .rnd (rnd),
         .out (s0_d)
      );
   end else begin : g_plain
      logic unused_rnd;
      assign unused_rnd = ^rnd;
      assign s0_d       = in;
   end

   // Data registers are never gated by valid: invalid words shift as well.
   for (genvar gs = 0; gs < LAT; gs++) begin : g_stage
      logic [W-1:0] d_in;
      logic         v_in;
      logic [W-1:0] q;
      logic         v;

      if (gs == 0) begin : g_head
         assign d_in = s0_d;
         assign v_in = in_valid;
      end else begin : g_body
         assign d_in = stage_q[gs-1];
         assign v_in = valid_q[gs-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
            v <= 1'b0;
         end else if (en) begin
            q <= d_in;
            v <= v_in;
         end
      end

      assign stage_q[gs] = q;
      assign valid_q[gs] = v;
   end

   assign out       = stage_q[LAT-1];
   assign out_valid = valid_q[LAT-1];

endmodule

// File: doc/msk_reg_pipe.md
Name: msk_reg_pipe

Overview:
- Parametrised masked pipeline register for Boolean sharings: a chain of LAT register stages carrying count masked bits of d shares each.
- Adds a stall enable, a valid bit travelling with the data, asynchronous active-low reset, and optional share refresh at the pipeline entry.
- Used wherever a sharing must be delayed by more than one cycle or re-masked before reuse: gadget latency balancing and between S-box rounds.
- Shares are never recombined inside the block.

Parameters:
- d, 2, number of shares per masked bit (>=1; REFRESH=1 requires d>=2).
- count, 1, number of masked bits carried.
- LAT, 2, number of register stages, i.e. latency in enabled cycles (>=1).
- REFRESH, 0, 1 = re-mask at stage 0 using rnd; 0 = plain delay, rnd ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 = all stages hold.
- in_valid  input  1  qualifies in; sampled when en=1.
- in  input  count*d  input sharing; bit i share j at index i*d+j. psim sharing, latency 0.
- rnd  input  RNDW  fresh randomness. RNDW = count*(d-1) if d>1, else 1. Bit i mask k at index i*(d-1)+k. Must be fresh each enabled cycle when REFRESH=1.
- out  output  count*d  output sharing, same layout as in. psim sharing, latency LAT.
- out_valid  output  1  qualifies out.

Behaviour:
- Reset: rst_n low clears all LAT data stages and all valid bits to 0 immediately, without waiting for clk. While rst_n is low, out=0 and out_valid=0. First capture happens on the first rising clk edge with rst_n high.
- Stage 0 capture on a rising edge with en=1:
  - REFRESH=0: stage0 <= in.
  - REFRESH=1, for each bit i:
    - share j<d-1 <= in[i*d+j] ^ rnd[i*(d-1)+j].
    - share d-1 <= in[i*d+d-1] ^ (XOR over k of rnd[i*(d-1)+k]).
  - The unshared value is preserved.
  - Each share's logic depends only on that share of in plus randomness. No cross-share terms on in.
- Shifting: on a rising edge with en=1, stage k <= stage k-1 for k=1..LAT-1. The valid chain shifts in parallel, with v0 <= in_valid.
- Hold: en=0 holds all data and valid registers. in, in_valid and rnd are ignored that cycle.
- Output: out = stage LAT-1 and out_valid = v LAT-1, driven directly from registers with no output logic (glitch-free boundary).
- Latency: with en held high, data presented at edge t appears on out after edge t+LAT-1, i.e. LAT cycles after presentation. Stalls extend latency one-for-one.
- Invalid data still shifts. Data registers are not gated by in_valid, so the datapath carries no control-dependent masking leakage.
- Boundaries:
  - LAT=1 degenerates to a single register plus valid bit, with optional refresh.
  - d=1 with REFRESH=1 is illegal: elaboration error via generate-time check.
  - rst_n asserted mid-stream discards all in-flight sharings. out_valid drops in the same cycle.
  - en toggling every cycle: each accepted word still emerges exactly once, in order.
- Annotation: module is psim_prop "affine", psim_order=d. The clock port is typed clock; in/out are typed as sharings with the latencies above.

Decomposition:
- Shared package msk_pkg:
  - function rnd_width(d, count).
  - index helpers share_idx(bit, share, d) and rnd_idx(bit, k, d).
  - REFRESH encoding constants.
- One natural sub-module: msk_refresh_xor, the combinational stage-0 re-masking (count*d outputs). Instantiated only when REFRESH=1.
- The stage chain is a generate loop of per-stage registers in msk_reg_pipe.

Test Plan:
- Reset: d=2, count=4, LAT=3, drive in=8'hA5 with en=1, pulse rst_n low mid-cycle -> out=0 and out_valid=0 immediately, with no clock edge needed.
- Latency: REFRESH=0, en=1, in_valid=1 with in=8'h3C at edge 0, then in_valid=0 -> out=8'h3C and out_valid=1 after edge 2 only; out_valid=0 on the cycles before and after.
- Stall: same config, in=8'h3C valid at edge 0, en=0 for edges 1-4, en=1 afterwards -> out=8'h3C and out_valid=1 after edge 6; values unchanged during the stall.
- Refresh: d=3, count=2, LAT=1, in encodes bits (1,0), rnd=4'b1011 -> out shares differ from in by the mask pattern; per-bit XOR of shares = (1,0); 1000 random rnd vectors all preserve the unshared value.
- Back-to-back with en toggling 1,0,1,0: stream of 6 valid words -> exactly 6 out_valid pulses, in order, data bit-exact with REFRESH=0.
- LAT=1, d=1, count=1: in=1 valid -> out=1 and out_valid=1 one cycle later. REFRESH=1 with d=1 fails elaboration.
